// File: rtl/bus_pkg.sv
// Shared types and constants for the register-transfer bus: FSM states,
// default source/destination indices and a zero-extension helper.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Working width of the zero-extension helper; bus widths up to this are supported.
    localparam int ZX_W = 32;

    localparam int SRC_HOLD = 0;
    localparam int AC       = 1;
    localparam int R1       = 2;
    localparam int R2       = 3;
    localparam int MDR      = 5;
    localparam int SR1      = 6;
    localparam int SR2      = 7;
    localparam int SR3      = 8;
    localparam int RRR      = 9;
    localparam int CRR      = 10;

    function automatic logic [ZX_W-1:0] zext(input logic [ZX_W-1:0] v, input int w);
        logic [ZX_W-1:0] m;
        if (w >= ZX_W) m = '1;
        else           m = (ZX_W'(1) << w) - ZX_W'(1);
        return v & m;
    endfunction

endpackage

// File: rtl/bus_src_mux.sv
// Combinational source selection: immediate override, index decode,
// narrow-source zero-extension and the hold flag for reserved/out-of-range indices.
module bus_src_mux #(
    parameter int                 DATA_W     = 16,
    parameter int                 NUM_SRC    = 12,
    parameter int                 NARROW_W   = 8,
    parameter logic [NUM_SRC-1:0] SRC_NARROW = 12'b0111_1110_0000,
    parameter int                 IMM_W      = 4,
    parameter int                 SEL_W      = $clog2(NUM_SRC) + 1
) (
    input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
    input  logic [SEL_W-1:0]          i_sel,
    input  logic                      i_imm_en,
    input  logic [IMM_W-1:0]          i_imm,
    output logic [DATA_W-1:0]         o_value,
    output logic                      o_hold
);
    import bus_pkg::*;

    always_comb begin
        o_value = '0;
        o_hold  = 1'b0;
        if (i_imm_en) begin
            o_value = DATA_W'(zext(ZX_W'(i_imm), IMM_W));
        end else if (i_sel == SEL_W'(SRC_HOLD) || i_sel >= SEL_W'(NUM_SRC)) begin
            o_hold = 1'b1;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (i_sel == SEL_W'(i)) begin
                    o_value = SRC_NARROW[i]
                        ? DATA_W'(zext(ZX_W'(i_src_data[i*DATA_W +: DATA_W]), NARROW_W))
                        : i_src_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/bus_xfer_unit.sv
// Register-transfer bus: accepts a command, loads the selected value onto the
// registered bus, then strobes the destination write enables for one cycle.
module bus_xfer_unit #(
    parameter int                 DATA_W     = 16,
    parameter int                 NUM_SRC    = 12,
    parameter int                 NUM_DST    = 8,
    parameter int                 NARROW_W   = 8,
    parameter logic [NUM_SRC-1:0] SRC_NARROW = 12'b0111_1110_0000,
    parameter int                 IMM_W      = 4,
    parameter logic [DATA_W-1:0]  RESET_VAL  = 16'h0007,
    parameter int                 SEL_W      = $clog2(NUM_SRC) + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [SEL_W-1:0]          cmd_src,
    input  logic                      cmd_imm_en,
    input  logic [IMM_W-1:0]          cmd_imm,
    input  logic [NUM_DST-1:0]        cmd_dst_mask,
    output logic [DATA_W-1:0]         bus_out,
    output logic [NUM_DST-1:0]        dst_we,
    output logic                      done,
    output logic                      busy
);
    import bus_pkg::*;

    state_t               r_state;
    state_t               w_next;
    logic [SEL_W-1:0]     r_src;
    logic                 r_imm_en;
    logic [IMM_W-1:0]     r_imm;
    logic [NUM_DST-1:0]   r_mask;
    logic [DATA_W-1:0]    r_bus;
    logic [DATA_W-1:0]    w_sel_value;
    logic                 w_hold;
    logic                 w_accept;

    bus_src_mux #(
        .DATA_W     (DATA_W),
        .NUM_SRC    (NUM_SRC),
        .NARROW_W   (NARROW_W),
        .SRC_NARROW (SRC_NARROW),
        .IMM_W      (IMM_W),
        .SEL_W      (SEL_W)
    ) u_src_mux (
        .i_src_data (src_data),
        .i_sel      (r_src),
        .i_imm_en   (r_imm_en),
        .i_imm      (r_imm),
        .o_value    (w_sel_value),
        .o_hold     (w_hold)
    );

    // Ready is withheld while reset is asserted so no command slips in during reset.
    always_comb begin
        cmd_ready = (r_state != LOAD) && !reset;
        w_accept  = cmd_valid && cmd_ready;
        dst_we    = '0;
        done      = 1'b0;
        busy      = (r_state != IDLE);
        w_next    = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = LOAD;
            LOAD:    w_next = WRITE;
            WRITE: begin
                dst_we = r_mask;
                done   = 1'b1;
                w_next = w_accept ? LOAD : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_bus    <= RESET_VAL;
            r_src    <= '0;
            r_imm_en <= 1'b0;
            r_imm    <= '0;
            r_mask   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_src    <= cmd_src;
                r_imm_en <= cmd_imm_en;
                r_imm    <= cmd_imm;
                r_mask   <= cmd_dst_mask;
            end
            if (r_state == LOAD && !w_hold) r_bus <= w_sel_value;
        end
    end

    assign bus_out = r_bus;

endmodule

// File: tb/tb_bus_xfer_unit.sv
// Self-checking bench for bus_xfer_unit: directed vector table, handwritten
// multi-cycle sequences and randomized transfers against a behavioural model.
module tb_bus_xfer_unit;
    import bus_pkg::*;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [191:0]  src_data = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [4:0]    cmd_src = '0;
    logic          cmd_imm_en = 1'b0;
    logic [3:0]    cmd_imm = '0;
    logic [7:0]    cmd_dst_mask = '0;
    logic [15:0]   bus_out;
    logic [7:0]    dst_we;
    logic          done;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] src_arr [12];
    logic [15:0] m_bus;
    logic [11:0] narrow_map = 12'b0111_1110_0000;

    typedef struct {
        int          src;
        bit          imm_en;
        logic [3:0]  imm;
        logic [7:0]  mask;
        logic [15:0] val;
        logic [15:0] exp_bus;
        logic [7:0]  exp_we;
    } vec_t;
    vec_t vecs [13];

    bus_xfer_unit dut (
        .clock        (clock),
        .reset        (reset),
        .src_data     (src_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_src      (cmd_src),
        .cmd_imm_en   (cmd_imm_en),
        .cmd_imm      (cmd_imm),
        .cmd_dst_mask (cmd_dst_mask),
        .bus_out      (bus_out),
        .dst_we       (dst_we),
        .done         (done),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural rule: immediate wins, index 0 or >= 12 holds, narrow sources keep low byte.
    function automatic logic [15:0] ref_bus(input int idx, input bit imm_en, input logic [3:0] imm,
                                            input logic [15:0] val, input logic [15:0] prev);
        if (imm_en) return 16'(imm);
        if (idx == 0 || idx >= 12) return prev;
        if (narrow_map[idx]) return val % 16'd256;
        return val;
    endfunction

    task automatic drive_sources();
        for (int i = 0; i < 12; i++) src_data[i*16 +: 16] = src_arr[i];
    endtask

    task automatic wait_edge();
        @(posedge clock);
        #1;
    endtask

    // One isolated transfer starting from IDLE; src_data is scrambled until after E0
    // so that a design sampling sources at acceptance is caught.
    task automatic xfer(input string tag, input int idx, input bit imm_en, input logic [3:0] imm,
                        input logic [7:0] mask, input logic [15:0] val,
                        input logic [15:0] exp_bus, input logic [7:0] exp_we);
        for (int i = 0; i < 12; i++) src_arr[i] = 16'($urandom);
        if (idx < 12) src_arr[idx] = val;
        src_data     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        cmd_valid    = 1'b1;
        cmd_src      = 5'(idx);
        cmd_imm_en   = imm_en;
        cmd_imm      = imm;
        cmd_dst_mask = mask;
        chk({tag, ".ready_idle"}, 32'(cmd_ready), 32'd1);
        wait_edge();
        cmd_valid = 1'b0;
        cmd_src   = 5'($urandom);
        cmd_dst_mask = 8'($urandom);
        drive_sources();
        chk({tag, ".ready_load"}, 32'(cmd_ready), 32'd0);
        chk({tag, ".busy_load"}, 32'(busy), 32'd1);
        chk({tag, ".we_load"}, 32'(dst_we), 32'd0);
        chk({tag, ".bus_load"}, 32'(bus_out), 32'(m_bus));
        wait_edge();
        chk({tag, ".bus_e1"}, 32'(bus_out), 32'(exp_bus));
        chk({tag, ".we_e1"}, 32'(dst_we), 32'(exp_we));
        chk({tag, ".done_e1"}, 32'(done), 32'd1);
        chk({tag, ".ready_write"}, 32'(cmd_ready), 32'd1);
        wait_edge();
        chk({tag, ".we_e2"}, 32'(dst_we), 32'd0);
        chk({tag, ".done_e2"}, 32'(done), 32'd0);
        chk({tag, ".busy_e2"}, 32'(busy), 32'd0);
        chk({tag, ".bus_e2"}, 32'(bus_out), 32'(exp_bus));
        m_bus = exp_bus;
    endtask

    initial begin
        vecs[0]  = '{MDR,  1'b0, 4'h0, 8'h04, 16'hABCD, 16'h00CD, 8'h04};
        vecs[1]  = '{0,    1'b1, 4'hA, 8'h0C, 16'h0000, 16'h000A, 8'h0C};
        vecs[2]  = '{15,   1'b0, 4'h0, 8'h80, 16'h0000, 16'h000A, 8'h80};
        vecs[3]  = '{SRC_HOLD, 1'b0, 4'h0, 8'hFF, 16'h0000, 16'h000A, 8'hFF};
        vecs[4]  = '{AC,   1'b0, 4'h0, 8'h01, 16'h1234, 16'h1234, 8'h01};
        vecs[5]  = '{SRC_HOLD, 1'b0, 4'h0, 8'h02, 16'h0000, 16'h1234, 8'h02};
        vecs[6]  = '{CRR,  1'b0, 4'h0, 8'h40, 16'hFFEE, 16'h00EE, 8'h40};
        vecs[7]  = '{11,   1'b0, 4'h0, 8'h20, 16'hBEEF, 16'hBEEF, 8'h20};
        vecs[8]  = '{R2,   1'b0, 4'h0, 8'h00, 16'h5555, 16'h5555, 8'h00};
        vecs[9]  = '{SR2,  1'b1, 4'h0, 8'h10, 16'h9999, 16'h0000, 8'h10};
        vecs[10] = '{SR1,  1'b0, 4'h0, 8'h08, 16'h1280, 16'h0080, 8'h08};
        vecs[11] = '{12,   1'b0, 4'h0, 8'hC3, 16'h0000, 16'h0080, 8'hC3};
        vecs[12] = '{4,    1'b0, 4'h0, 8'h81, 16'hA5A5, 16'hA5A5, 8'h81};

        for (int i = 0; i < 12; i++) src_arr[i] = '0;
        m_bus = 16'h0007;

        // Reset behaviour
        repeat (2) wait_edge();
        cmd_valid = 1'b1;
        chk("rst.ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        reset = 1'b0;
        wait_edge();
        chk("rst.bus", 32'(bus_out), 32'h0007);
        chk("rst.we", 32'(dst_we), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.ready_after", 32'(cmd_ready), 32'd1);

        // Directed vector table
        for (int v = 0; v < 13; v++)
            xfer($sformatf("vec%0d", v), vecs[v].src, vecs[v].imm_en, vecs[v].imm,
                 vecs[v].mask, vecs[v].val, vecs[v].exp_bus, vecs[v].exp_we);

        // Back-to-back with cmd_valid held
        src_arr[AC] = 16'h1234;
        src_arr[R1] = 16'h5678;
        drive_sources();
        cmd_valid = 1'b1; cmd_imm_en = 1'b0; cmd_src = 5'(AC); cmd_dst_mask = 8'h01;
        wait_edge();
        cmd_src = 5'(R1); cmd_dst_mask = 8'h02;
        chk("b2b.ready_load1", 32'(cmd_ready), 32'd0);
        wait_edge();
        chk("b2b.bus_e1", 32'(bus_out), 32'h1234);
        chk("b2b.we_e1", 32'(dst_we), 32'h01);
        chk("b2b.ready_write", 32'(cmd_ready), 32'd1);
        wait_edge();
        cmd_valid = 1'b0;
        chk("b2b.ready_load2", 32'(cmd_ready), 32'd0);
        chk("b2b.bus_e2", 32'(bus_out), 32'h1234);
        chk("b2b.done_e2", 32'(done), 32'd0);
        wait_edge();
        chk("b2b.bus_e3", 32'(bus_out), 32'h5678);
        chk("b2b.we_e3", 32'(dst_we), 32'h02);
        chk("b2b.done_e3", 32'(done), 32'd1);
        wait_edge();
        chk("b2b.idle", 32'(busy), 32'd0);
        chk("b2b.done_e4", 32'(done), 32'd0);

        // Reset during WRITE aborts the transfer
        src_arr[RRR] = 16'h3C3C;
        drive_sources();
        cmd_valid = 1'b1; cmd_src = 5'(RRR); cmd_dst_mask = 8'hF0;
        wait_edge();
        cmd_valid = 1'b0;
        wait_edge();
        chk("rstw.in_write", 32'(done), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstw.ready", 32'(cmd_ready), 32'd0);
        wait_edge();
        chk("rstw.we", 32'(dst_we), 32'd0);
        chk("rstw.done", 32'(done), 32'd0);
        chk("rstw.bus", 32'(bus_out), 32'h0007);
        reset = 1'b0;
        wait_edge();

        // Reset during LOAD: no strobes ever appear for the aborted command
        cmd_valid = 1'b1; cmd_src = 5'(RRR); cmd_dst_mask = 8'h0F;
        wait_edge();
        cmd_valid = 1'b0;
        reset = 1'b1;
        wait_edge();
        reset = 1'b0;
        chk("rstl.bus", 32'(bus_out), 32'h0007);
        chk("rstl.busy", 32'(busy), 32'd0);
        wait_edge();
        chk("rstl.we", 32'(dst_we), 32'd0);
        chk("rstl.done", 32'(done), 32'd0);
        m_bus = 16'h0007;

        // Randomized transfers against the behavioural model
        for (int n = 0; n < 150; n++) begin
            int          idx;
            bit          ie;
            logic [3:0]  im;
            logic [7:0]  mk;
            logic [15:0] vl;
            idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 12));
            ie  = ($urandom_range(0, 3) == 0);
            im  = 4'($urandom);
            mk  = 8'($urandom);
            vl  = 16'($urandom);
            xfer($sformatf("rnd%0d", n), idx, ie, im, mk, vl, ref_bus(idx, ie, im, vl, m_bus), mk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_xfer_unit.md
# bus_xfer_unit

Parametrised register-transfer bus for the processor datapath. One command moves a value from any one of NUM_SRC sources, or from an instruction immediate, onto a registered bus. The value is then written to any subset of NUM_DST destination registers. Transfers use a valid/ready handshake, and a two-state pipeline allows one transfer every two cycles.

## Interface
Parameters:
- DATA_W, 16, bus width
- NUM_SRC, 12, number of source ports
- NUM_DST, 8, number of destination write strobes
- NARROW_W, 8, width of narrow sources
- SRC_NARROW, 12'b0111_1110_0000, bit i set means source i is NARROW_W wide and is zero-extended
- IMM_W, 4, immediate field width
- RESET_VAL, 16'h0007, bus value after reset
- SEL_W, $clog2(NUM_SRC)+1, source-select width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- src_data  in  NUM_SRC*DATA_W  flattened source values; source i occupies bits [i*DATA_W +: DATA_W]
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_src  in  SEL_W  source index
- cmd_imm_en  in  1  use cmd_imm instead of a source
- cmd_imm  in  IMM_W  immediate value (instruction field)
- cmd_dst_mask  in  NUM_DST  destination strobes to fire; may hold several bits (broadcast)
- bus_out  out  DATA_W  registered bus value; destinations read this
- dst_we  out  NUM_DST  per-destination write enable
- done  out  1  one-cycle pulse, transfer complete
- busy  out  1  state is not IDLE

## Operation
- States:
  - IDLE: cmd_ready=1.
  - LOAD: cmd_ready=0.
  - WRITE: cmd_ready=1.
- On acceptance, latch cmd_src, cmd_imm_en, cmd_imm and cmd_dst_mask, then go to LOAD.
- LOAD: sample the selected value into bus_out, then go to WRITE.
- Source selection during LOAD, in priority order:
  - cmd_imm_en=1: bus_out ← zero-extended cmd_imm.
  - Source index < NUM_SRC: bus_out ← src_data[index]. Bits above NARROW_W are zeroed when SRC_NARROW[index]=1.
  - Source index ≥ NUM_SRC: hold; bus_out unchanged.
- WRITE:
  - dst_we = latched mask; done=1.
  - A command accepted in WRITE goes to LOAD. Otherwise go to IDLE.
- Zero mask: the bus still loads, dst_we stays 0, and done still pulses.
- dst_we and done are decoded from state only, never from inputs.

## Timing
- Reset values: state IDLE, bus_out=RESET_VAL, dst_we=0, done=0, busy=0. cmd_ready=0 during any cycle with reset=1.
- Reset in LOAD or WRITE aborts the transfer. At the following edge the reset values above apply. No dst_we or done is produced for the aborted command.
- Acceptance edge E0.
  - E1: bus_out updated, using src_data sampled at E1.
  - Cycle E1–E2: dst_we and done high.
  - E2: destinations capture bus_out, which is stable across E1–E2.
- Throughput: back-to-back commands are accepted at E0, E2, E4, …
- bus_out changes only at the LOAD→WRITE edge or on reset.

## Structure
- Package bus_pkg:
  - State enum: IDLE, LOAD, WRITE.
  - Function for zero-extension.
  - Default source/destination index constants: AC=1, R1=2, R2=3, MDR=5, SR1=6, SR2=7, SR3=8, RRR=9, CRR=10.
  - SRC_HOLD=0 constant. Index 0 is a reserved source meaning hold: it leaves bus_out unchanged, the same as an out-of-range index.
- Sub-module bus_src_mux: combinational selection covering index decode, narrow zero-extension, immediate override and the hold flag.
- Top level: FSM, command latch, bus register, strobe decode.

## Test plan
- Reset, then idle: bus_out=0x0007, dst_we=0, cmd_ready=1 one cycle after reset falls.
- Narrow source: src 5 = 0xABCD with SRC_NARROW[5]=1, mask 8'b0000_0100 → bus_out=0x00CD at E1, dst_we=0x04 for exactly one cycle, done pulses.
- Immediate broadcast: cmd_imm_en=1, cmd_imm=4'hA, mask 8'h0C → bus_out=0x000A, dst_we=0x0C.
- Hold: cmd_src=15 (≥ NUM_SRC) and cmd_src=0 (SRC_HOLD) each leave bus_out unchanged; done pulses, dst_we follows mask.
- Back-to-back: cmd_valid held with src 1=0x1234 then src 2=0x5678 → accepts at E0 and E2; bus_out 0x1234 at E1, 0x5678 at E3; cmd_ready=0 in LOAD.
- Reset asserted during WRITE → dst_we=0 and done=0 at the next cycle, bus_out=0x0007.
